// File: rtl/imm_encoder.sv
// RV32I instruction packer: immediate + register/funct fields -> one instruction word,
// with an LI mode that expands a 32-bit constant into LUI/ADDI over a valid/ready stream.
module imm_encoder #(
  parameter bit LI_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  typedef enum logic {IDLE, PEND} state_e;

  localparam logic [2:0] SEL_I  = 3'd0;
  localparam logic [2:0] SEL_S  = 3'd1;
  localparam logic [2:0] SEL_B  = 3'd2;
  localparam logic [2:0] SEL_U  = 3'd3;
  localparam logic [2:0] SEL_J  = 3'd4;
  localparam logic [2:0] SEL_LI = 3'd5;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;
  logic [31:0] pend_q, pend_d;

  logic        fits12, fits13, fits21;
  logic [19:0] li_hi;
  logic [31:0] enc_inst, enc_addi;
  logic        enc_err, enc_last, enc_two;
  logic        accept, out_fire;

  // Range checks: the bits above the encodable field must be a pure sign extension.
  assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // (imm + 0x800)[31:12]: the low-half carry happens exactly when imm[11] is set,
  // compensating for the sign extension ADDI applies to imm[11:0].
  assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

  always_comb begin
    enc_inst = '0;
    enc_err  = 1'b0;
    enc_last = 1'b1;
    enc_two  = 1'b0;
    enc_addi = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};
    case (in_sel)
      SEL_I: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = ~fits12;
      end
      SEL_S: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = ~fits12;
      end
      SEL_B: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = ~fits13 | in_imm[0];
      end
      SEL_U: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = |in_imm[11:0];
      end
      SEL_J: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = ~fits21 | in_imm[0];
      end
      SEL_LI: begin
        if (!LI_ENABLE) begin
          enc_err = 1'b1;
        end else if (fits12) begin
          enc_inst = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
        end else if (in_imm[11:0] == 12'd0) begin
          enc_inst = {in_imm[31:12], in_rd, OP_LUI};
        end else begin
          enc_inst = {li_hi, in_rd, OP_LUI};
          enc_last = 1'b0;
          enc_two  = 1'b1;
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    pend_d      = pend_q;
    if (state_q == PEND) begin
      // The queued ADDI follows the LUI on the cycle after its handshake.
      if (out_fire) begin
        out_valid_d = 1'b1;
        out_inst_d  = pend_q;
        out_err_d   = 1'b0;
        out_last_d  = 1'b1;
        state_d     = IDLE;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_err_d   = enc_err;
      out_last_d  = enc_last;
      if (enc_two) begin
        pend_d  = enc_addi;
        state_d = PEND;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      pend_q      <= pend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

endmodule
